// File: rtl/bus_arbiter_if.sv
// Bundle of client-side and server-side bus signals for the round-robin arbiter.
// master is the arbiter's view; slave is the view of the surrounding clients/server.
interface bus_arbiter_if #(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [N_CLIENTS-1:0]            cl_rq;
  logic [N_CLIENTS*ADDR_WIDTH-1:0] cl_addr;
  logic [N_CLIENTS-1:0]            cl_wr_ni;
  logic [N_CLIENTS*DATA_WIDTH-1:0] cl_dataW;
  logic [N_CLIENTS-1:0]            cl_ack;
  logic [DATA_WIDTH-1:0]           cl_dataR;
  logic                            srv_rq;
  logic [ADDR_WIDTH-1:0]           srv_addr;
  logic                            srv_wr_ni;
  logic [DATA_WIDTH-1:0]           srv_dataW;
  logic                            srv_ack;
  logic [DATA_WIDTH-1:0]           srv_dataR;
  logic [N_CLIENTS-1:0]            gnt;
  logic                            busy;
  logic                            timeout_err;

  modport master (
    input  cl_rq, cl_addr, cl_wr_ni, cl_dataW, srv_ack, srv_dataR,
    output cl_ack, cl_dataR, srv_rq, srv_addr, srv_wr_ni, srv_dataW,
           gnt, busy, timeout_err
  );

  modport slave (
    output cl_rq, cl_addr, cl_wr_ni, cl_dataW, srv_ack, srv_dataR,
    input  cl_ack, cl_dataR, srv_rq, srv_addr, srv_wr_ni, srv_dataW,
           gnt, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus server among N_CLIENTS clients, with
// withdraw and server-timeout aborts.
module bus_arbiter #(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(N_CLIENTS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0] ptr_after;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;

  // Search ptr, ptr+1, ... with wrap; the first requester found wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(N_CLIENTS))
        cand = cand - (IDX_W + 1)'(N_CLIENTS);
      if (!pick_valid && bus.cl_rq[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_after = (gnt_idx == IDX_W'(N_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    bus.srv_addr  = '0;
    bus.srv_wr_ni = 1'b0;
    bus.srv_dataW = '0;
    if (bus.gnt != '0) begin
      bus.srv_addr  = bus.cl_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      bus.srv_wr_ni = bus.cl_wr_ni[gnt_idx];
      bus.srv_dataW = bus.cl_dataW[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.busy = (state != IDLE);

  // Completion beats withdraw, which beats timeout; pulses last one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      gnt_idx         <= '0;
      wait_cnt        <= '0;
      bus.gnt         <= '0;
      bus.srv_rq      <= 1'b0;
      bus.cl_ack      <= '0;
      bus.cl_dataR    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.cl_ack      <= '0;
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= GRANT;
            gnt_idx    <= pick_idx;
            bus.gnt    <= N_CLIENTS'(1) << pick_idx;
            bus.srv_rq <= 1'b1;
            wait_cnt   <= '0;
          end
        end
        GRANT: begin
          if (bus.srv_ack) begin
            bus.cl_ack   <= bus.gnt;
            bus.cl_dataR <= bus.srv_dataR;
            bus.srv_rq   <= 1'b0;
            bus.gnt      <= '0;
            ptr          <= ptr_after;
            state        <= RELEASE;
          end else if (!bus.cl_rq[gnt_idx]) begin
            bus.srv_rq <= 1'b0;
            bus.gnt    <= '0;
            ptr        <= ptr_after;
            state      <= IDLE;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            bus.srv_rq      <= 1'b0;
            bus.gnt         <= '0;
            ptr             <= ptr_after;
            state           <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant/ack, round-robin order, wrap, timeout,
// withdraw and mid-transaction reset.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   check_count = 0;
  int   error_count = 0;
  int   ack_seen [4];

  bus_arbiter_if #(.N_CLIENTS(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_if ();

  bus_arbiter #(
    .N_CLIENTS(4), .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after an edge so the next edge samples them cleanly.
  task automatic applyStimulus(input logic [3:0] rq, input logic ack,
                               input logic [7:0] data);
    bus_if.cl_rq     = rq;
    bus_if.srv_ack   = ack;
    bus_if.srv_dataR = data;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    bus_if.cl_addr   = {4'hD, 4'hC, 4'hB, 4'hA};
    bus_if.cl_dataW  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus_if.cl_wr_ni  = 4'b0101;
    bus_if.cl_rq     = '0;
    bus_if.srv_ack   = 1'b0;
    bus_if.srv_dataR = '0;

    applyStimulus(4'b0000, 1'b0, 8'h00);
    checkOutput("rst_gnt", 32'(bus_if.gnt), 32'h0);
    checkOutput("rst_srv_rq", 32'(bus_if.srv_rq), 32'h0);
    checkOutput("rst_busy", 32'(bus_if.busy), 32'h0);
    checkOutput("rst_cl_ack", 32'(bus_if.cl_ack), 32'h0);
    checkOutput("rst_dataR", 32'(bus_if.cl_dataR), 32'h0);
    checkOutput("rst_tmo", 32'(bus_if.timeout_err), 32'h0);
    reset = 1'b0;

    // Single read by client 0.
    applyStimulus(4'b0001, 1'b0, 8'h00);
    checkOutput("t1_gnt", 32'(bus_if.gnt), 32'h1);
    checkOutput("t1_srv_rq", 32'(bus_if.srv_rq), 32'h1);
    checkOutput("t1_addr", 32'(bus_if.srv_addr), 32'hA);
    checkOutput("t1_wr_ni", 32'(bus_if.srv_wr_ni), 32'h1);
    checkOutput("t1_dataW", 32'(bus_if.srv_dataW), 32'h11);
    checkOutput("t1_busy", 32'(bus_if.busy), 32'h1);
    applyStimulus(4'b0001, 1'b1, 8'hA5);
    checkOutput("t1_ack", 32'(bus_if.cl_ack), 32'h1);
    checkOutput("t1_dataR", 32'(bus_if.cl_dataR), 32'hA5);
    checkOutput("t1_rq_low", 32'(bus_if.srv_rq), 32'h0);
    checkOutput("t1_rel_gnt", 32'(bus_if.gnt), 32'h0);
    applyStimulus(4'b0000, 1'b0, 8'h00);
    checkOutput("t1_idle_ack", 32'(bus_if.cl_ack), 32'h0);
    checkOutput("t1_idle_busy", 32'(bus_if.busy), 32'h0);

    // All clients request continuously; expected order 0,1,2,3,0.
    applyReset();
    for (int c = 0; c < 4; c++) ack_seen[c] = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b0, 8'h00);
      checkOutput($sformatf("rr%0d_gnt", k), 32'(bus_if.gnt), 32'(1) << (k % 4));
      applyStimulus(4'b1111, 1'b0, 8'h00);
      applyStimulus(4'b1111, 1'b1, 8'(8'h30 + k));
      checkOutput($sformatf("rr%0d_ack", k), 32'(bus_if.cl_ack), 32'(1) << (k % 4));
      checkOutput($sformatf("rr%0d_dataR", k), 32'(bus_if.cl_dataR), 32'h30 + k);
      for (int c = 0; c < 4; c++) if (bus_if.cl_ack[c]) ack_seen[c]++;
      applyStimulus(4'b1111, 1'b0, 8'h00);
      checkOutput($sformatf("rr%0d_pulse", k), 32'(bus_if.cl_ack), 32'h0);
    end
    checkOutput("rr_acks0", 32'(ack_seen[0]), 32'd2);
    checkOutput("rr_acks1", 32'(ack_seen[1]), 32'd1);
    checkOutput("rr_acks2", 32'(ack_seen[2]), 32'd1);
    checkOutput("rr_acks3", 32'(ack_seen[3]), 32'd1);

    // Serve client 1 so ptr=2, then 0011 must wrap to client 0, leaving ptr=1.
    applyReset();
    applyStimulus(4'b0010, 1'b0, 8'h00);
    checkOutput("wr_gnt1", 32'(bus_if.gnt), 32'h2);
    applyStimulus(4'b0010, 1'b1, 8'h01);
    applyStimulus(4'b0000, 1'b0, 8'h00);
    applyStimulus(4'b0011, 1'b0, 8'h00);
    checkOutput("wr_gnt0", 32'(bus_if.gnt), 32'h1);
    checkOutput("wr_addr", 32'(bus_if.srv_addr), 32'hA);
    applyStimulus(4'b0011, 1'b1, 8'h02);
    checkOutput("wr_ack0", 32'(bus_if.cl_ack), 32'h1);
    applyStimulus(4'b0011, 1'b0, 8'h00);
    applyStimulus(4'b0011, 1'b0, 8'h00);
    checkOutput("wr_ptr1", 32'(bus_if.gnt), 32'h2);
    checkOutput("wr_addr1", 32'(bus_if.srv_addr), 32'hB);
    checkOutput("wr_wr_ni1", 32'(bus_if.srv_wr_ni), 32'h0);
    applyStimulus(4'b0011, 1'b1, 8'h03);
    applyStimulus(4'b0000, 1'b0, 8'h00);

    // Timeout of 4 cycles on client 2 while client 3 waits.
    applyStimulus(4'b1100, 1'b0, 8'h00);
    checkOutput("to_gnt", 32'(bus_if.gnt), 32'h4);
    checkOutput("to_rq_c1", 32'(bus_if.srv_rq), 32'h1);
    for (int n = 2; n <= 4; n++) begin
      applyStimulus(4'b1100, 1'b0, 8'h00);
      checkOutput($sformatf("to_rq_c%0d", n), 32'(bus_if.srv_rq), 32'h1);
      checkOutput($sformatf("to_err_c%0d", n), 32'(bus_if.timeout_err), 32'h0);
    end
    applyStimulus(4'b1100, 1'b0, 8'h00);
    checkOutput("to_rq_drop", 32'(bus_if.srv_rq), 32'h0);
    checkOutput("to_err", 32'(bus_if.timeout_err), 32'h1);
    checkOutput("to_no_ack", 32'(bus_if.cl_ack), 32'h0);
    checkOutput("to_rel_gnt", 32'(bus_if.gnt), 32'h0);
    applyStimulus(4'b1100, 1'b0, 8'h00);
    checkOutput("to_err_clr", 32'(bus_if.timeout_err), 32'h0);
    applyStimulus(4'b1000, 1'b0, 8'h00);
    checkOutput("to_next_gnt", 32'(bus_if.gnt), 32'h8);
    checkOutput("to_next_data", 32'(bus_if.srv_dataW), 32'h44);
    applyStimulus(4'b1000, 1'b1, 8'h04);
    checkOutput("to_next_ack", 32'(bus_if.cl_ack), 32'h8);
    applyStimulus(4'b0000, 1'b0, 8'h00);

    // Withdraw in GRANT cycle 2: straight back to IDLE, no ack.
    applyStimulus(4'b0001, 1'b0, 8'h00);
    checkOutput("wd_gnt", 32'(bus_if.gnt), 32'h1);
    applyStimulus(4'b0001, 1'b0, 8'h00);
    applyStimulus(4'b0000, 1'b0, 8'h00);
    checkOutput("wd_rq", 32'(bus_if.srv_rq), 32'h0);
    checkOutput("wd_gnt0", 32'(bus_if.gnt), 32'h0);
    checkOutput("wd_ack", 32'(bus_if.cl_ack), 32'h0);
    checkOutput("wd_busy", 32'(bus_if.busy), 32'h0);

    // Ack on the same edge as withdraw still completes.
    applyStimulus(4'b0010, 1'b0, 8'h00);
    checkOutput("wa_gnt", 32'(bus_if.gnt), 32'h2);
    applyStimulus(4'b0000, 1'b1, 8'h5A);
    checkOutput("wa_ack", 32'(bus_if.cl_ack), 32'h2);
    checkOutput("wa_dataR", 32'(bus_if.cl_dataR), 32'h5A);
    checkOutput("wa_busy", 32'(bus_if.busy), 32'h1);
    applyStimulus(4'b0000, 1'b1, 8'h66);
    checkOutput("rel_ack_ign", 32'(bus_if.cl_ack), 32'h0);
    applyStimulus(4'b0000, 1'b1, 8'h77);
    checkOutput("idle_ack_ign", 32'(bus_if.cl_ack), 32'h0);
    checkOutput("idle_dataR", 32'(bus_if.cl_dataR), 32'h5A);

    // Reset during GRANT (ptr=2 here): outputs drop at once, ptr returns to 0.
    applyStimulus(4'b0001, 1'b0, 8'h00);
    checkOutput("mr_gnt", 32'(bus_if.gnt), 32'h1);
    checkOutput("mr_rq", 32'(bus_if.srv_rq), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mr_rq_drop", 32'(bus_if.srv_rq), 32'h0);
    checkOutput("mr_gnt_drop", 32'(bus_if.gnt), 32'h0);
    checkOutput("mr_busy", 32'(bus_if.busy), 32'h0);
    checkOutput("mr_addr", 32'(bus_if.srv_addr), 32'h0);
    applyStimulus(4'b1111, 1'b1, 8'h99);
    checkOutput("mr_no_ack", 32'(bus_if.cl_ack), 32'h0);
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b0, 8'h00);
    checkOutput("mr_restart", 32'(bus_if.gnt), 32'h1);
    applyStimulus(4'b1111, 1'b1, 8'h12);
    checkOutput("mr_ack", 32'(bus_if.cl_ack), 32'h1);
    applyStimulus(4'b0000, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one bus server among N_CLIENTS bus clients.
- Each client raises rq with address, wr_ni and dataW. The arbiter grants one client at a time and forwards that client's bus signals to the server.
- It returns the server's ack and read data to the granted client only.
- It also aborts transactions when the client withdraws or the server times out.

Parameters:
- N_CLIENTS, 4, number of clients; must be at least 2.
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 4, address bus width.
- TIMEOUT, 16, maximum cycles spent in GRANT waiting for srv_ack; 0 disables the timeout.
- Local IDX_W = $clog2(N_CLIENTS) sets the client index width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- cl_rq  in  N_CLIENTS  per-client request.
- cl_addr  in  N_CLIENTS*ADDR_WIDTH  packed client addresses; client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cl_wr_ni  in  N_CLIENTS  per-client operation select; 1 = read, 0 = write.
- cl_dataW  in  N_CLIENTS*DATA_WIDTH  packed client write data.
- cl_ack  out  N_CLIENTS  per-client acknowledge; one-cycle pulse.
- cl_dataR  out  DATA_WIDTH  read data, shared by all clients, valid while the matching cl_ack bit is high.
- srv_rq  out  1  request to the server.
- srv_addr  out  ADDR_WIDTH  address of the granted client.
- srv_wr_ni  out  1  operation select of the granted client.
- srv_dataW  out  DATA_WIDTH  write data of the granted client.
- srv_ack  in  1  server completion.
- srv_dataR  in  DATA_WIDTH  server read data, valid with srv_ack.
- gnt  out  N_CLIENTS  one-hot grant; all zero when idle.
- busy  out  1  high when the state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a timeout abort happens.

Behaviour:
- Reset is asynchronous, active-high. It forces: state=IDLE, ptr=0, gnt=0, srv_rq=0, cl_ack=0, cl_dataR=0, timeout_err=0, wait_cnt=0.
  - Reset mid-transaction drops srv_rq immediately and generates no ack.
- State machine with three states: IDLE, GRANT, RELEASE. All outputs are registered except the srv_addr, srv_wr_ni and srv_dataW mux.
  - The mux selects by the registered grant index. Outputs are 0 when gnt==0.
- IDLE:
  - If cl_rq != 0, pick the first set bit searching ptr, ptr+1, … with wrap modulo N_CLIENTS.
  - Next edge: state=GRANT, gnt=onehot(winner), srv_rq=1, wait_cnt=0.
  - Latency: cl_rq sampled at edge k gives srv_rq=1 after edge k.
- GRANT: evaluated every edge, in this priority order.
  - (1) srv_ack=1:
    - cl_ack[winner]=1 and cl_dataR=srv_dataR (captured for reads and writes alike).
    - srv_rq=0, ptr=winner+1 mod N, state=RELEASE.
  - (2) cl_rq[winner]=0 (client withdrew):
    - srv_rq=0, gnt=0, ptr=winner+1, state=IDLE; no ack.
  - (3) TIMEOUT!=0 and wait_cnt==TIMEOUT-1:
    - timeout_err=1, srv_rq=0, ptr=winner+1, state=RELEASE; no ack.
  - (4) Otherwise wait_cnt increments.
  - srv_ack on the same edge as a withdraw or a timeout counts as a completion: rule (1) wins.
- RELEASE: exactly one cycle.
  - gnt=0; cl_ack and timeout_err pulses are visible during this cycle.
  - Next edge: state=IDLE and pulses clear.
  - srv_ack arriving in RELEASE or IDLE is ignored.
- Turnaround: minimum 3 edges per completed transaction (grant, ack, release). Requests from other clients are held until IDLE; no preemption.
- Fairness: after any grant ends, that client has lowest priority. A client holding rq continuously is served within N_CLIENTS transactions.
- Invariants:
  - gnt is always one-hot or zero.
  - cl_ack has at most one bit set, and only for the client granted in the previous cycle.
  - srv_rq=1 only in GRANT.

Test Plan:
- After reset, cl_rq=0001 → gnt=0001 and srv_rq=1 one edge later. srv_addr follows client 0's address. srv_ack with srv_dataR=8'hA5 → next cycle cl_ack=0001, cl_dataR=A5, srv_rq=0. Then IDLE.
- cl_rq=1111 held, server acks each GRANT after 2 cycles → grant order 0,1,2,3,0; each client's cl_ack pulses exactly once per round.
- ptr=2 with cl_rq=0011 → client 0 granted (wrap). Afterwards ptr=1.
- TIMEOUT=4, no srv_ack → srv_rq high for exactly 4 cycles. timeout_err pulses, cl_ack stays 0, next requester granted afterwards.
- Client drops rq in cycle 2 of GRANT → srv_rq falls next edge, no ack, IDLE. Also: srv_ack and cl_rq drop on the same edge → ack delivered.
- Reset asserted in GRANT with srv_rq=1 → all outputs 0 immediately. After release, ptr=0 and arbitration restarts from client 0.
